operm_kp_gen: RTL and testbench

OPERM_KP_GEN -- requirements
Module: operm_kp_gen

---
 rtl/operm_pkg.sv | 25 ++
 rtl/operm_kp_lane.sv | 52 +++++
 rtl/operm_kp_gen.sv | 183 ++++++++++++++++++
 tb/tb_operm_kp_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : operm_pkg
//  Desc     : Shared mode encodings and FSM state type for the key-stream
//             generator of the output permutator.
//  Revision : 1.0 - initial release
// ============================================================================
package operm_pkg;

  // Address-generation modes carried on cfg_mode
  typedef enum logic [1:0] {
    ROTATE = 2'd0,
    BITREV = 2'd1,
    XOR    = 2'd2,
    IDENT  = 2'd3
  } mode_t;

  // Generator control states
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/operm_kp_lane.sv
`default_nettype none
// ============================================================================
//  Module   : operm_kp_lane
//  Desc     : Address computation for one permutator slice. The slice index
//             is a constant parameter, so bit-reverse folds to wiring.
//             Macro OPERM_KP_GEN_XOR_EN enables the xor mode datapath;
//             without it, xor mode falls back to identity.
//  Revision : 1.0 - initial release
// ============================================================================
module operm_kp_lane
  import operm_pkg::*;
#(
  parameter int LOG2SLICES = 5,
  parameter int IDX        = 0
) (
  input  mode_t                 mode,
  input  logic [LOG2SLICES-1:0] rot,
`ifdef OPERM_KP_GEN_XOR_EN
  input  logic [LOG2SLICES-1:0] shift,
`endif
  output logic [LOG2SLICES-1:0] addr
);

  localparam logic [LOG2SLICES-1:0] c_idx = IDX[LOG2SLICES-1:0];

  logic [LOG2SLICES-1:0] w_rev;

  // Bit-reversed slice index (constant after elaboration)
  always_comb begin
    w_rev = '0;
    for (int b = 0; b < LOG2SLICES; b++) begin
      w_rev[b] = c_idx[LOG2SLICES-1-b];
    end
  end

  // Select the slice address for the active mode; sums wrap modulo SLICES
  always_comb begin
    addr = c_idx;
    case (mode)
      ROTATE:  addr = c_idx + rot;
      BITREV:  addr = w_rev;
`ifdef OPERM_KP_GEN_XOR_EN
      XOR:     addr = c_idx ^ shift;
`else
      XOR:     addr = c_idx;
`endif
      default: addr = c_idx;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/operm_kp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : operm_kp_gen
//  Desc     : Programmable key-word generator for the output permutator.
//             A cfg handshake loads a program; the block then streams
//             cfg_count key words, each packing the sel field above one
//             address per slice. Macro OPERM_KP_GEN_XOR_EN enables xor mode.
//  Revision : 1.0 - initial release
// ============================================================================
module operm_kp_gen
  import operm_pkg::*;
#(
  parameter int SLICES     = 32,
  parameter int LOG2SLICES = 5,
  parameter int SELIN      = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               cfg_valid,
  output logic                               cfg_ready,
  input  logic [1:0]                         cfg_mode,
  input  logic [LOG2SLICES-1:0]              cfg_shift,
  input  logic [LOG2SLICES-1:0]              cfg_step,
  input  logic [15:0]                        cfg_count,
  input  logic [SELIN-1:0]                   cfg_sel,
  input  logic                               abort,
  output logic [SELIN+SLICES*LOG2SLICES-1:0] i_kp_dat,
  output logic                               i_kp_valid,
  input  logic                               i_kp_ready,
  output logic                               done
);

  localparam int c_aw = SLICES * LOG2SLICES;
  localparam int c_dw = SELIN + c_aw;

  state_t                 r_state;
  state_t                 w_state_next;
  mode_t                  r_mode;
  logic [LOG2SLICES-1:0]  r_rot;
  logic [LOG2SLICES-1:0]  r_step;
  logic [15:0]            r_count;
  logic [15:0]            r_k;
  logic [SELIN-1:0]       r_sel;
  logic                   r_valid;
  logic                   r_done;
  logic [c_dw-1:0]        r_dat;

  logic                   w_cfg_ready;
  logic                   w_cfg_fire;
  logic                   w_load;
  logic                   w_beat_fire;
  logic                   w_last;
  mode_t                  w_lane_mode;
  logic [LOG2SLICES-1:0]  w_lane_rot;
  logic [SELIN-1:0]       w_lane_sel;
  logic [c_aw-1:0]        w_addr;
  logic [c_dw-1:0]        w_dat;

`ifdef OPERM_KP_GEN_XOR_EN
  logic [LOG2SLICES-1:0]  r_shift;
  logic [LOG2SLICES-1:0]  w_lane_shift;
`endif

  // Handshake qualifiers; abort blocks a same-cycle cfg handshake
  assign w_cfg_fire  = cfg_valid && w_cfg_ready && !abort;
  assign w_load      = w_cfg_fire && (cfg_count != 16'd0);
  assign w_beat_fire = r_valid && i_kp_ready;
  assign w_last      = (r_k == (r_count - 16'd1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state and cfg_ready decode
  always_comb begin
    w_state_next = r_state;
    w_cfg_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_ready = 1'b1;
        if (w_load) w_state_next = RUN;
      end
      RUN: begin
        if (abort)                      w_state_next = IDLE;
        else if (w_beat_fire && w_last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Lane operands: the incoming program in IDLE, the next beat in RUN
  always_comb begin
    w_lane_mode = r_mode;
    w_lane_rot  = r_rot + r_step;
    w_lane_sel  = r_sel;
`ifdef OPERM_KP_GEN_XOR_EN
    w_lane_shift = r_shift;
`endif
    if (r_state == IDLE) begin
      w_lane_mode = mode_t'(cfg_mode);
      w_lane_rot  = cfg_shift;
      w_lane_sel  = cfg_sel;
`ifdef OPERM_KP_GEN_XOR_EN
      w_lane_shift = cfg_shift;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < SLICES; gi++) begin : g_lane
      operm_kp_lane #(
        .LOG2SLICES (LOG2SLICES),
        .IDX        (gi)
      ) u_lane (
        .mode  (w_lane_mode),
        .rot   (w_lane_rot),
`ifdef OPERM_KP_GEN_XOR_EN
        .shift (w_lane_shift),
`endif
        .addr  (w_addr[LOG2SLICES*gi +: LOG2SLICES])
      );
    end
  endgenerate

  assign w_dat = {w_lane_sel, w_addr};

  // Program latch, beat counter, rotation accumulator and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode  <= ROTATE;
      r_rot   <= '0;
      r_step  <= '0;
      r_count <= '0;
      r_k     <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_dat   <= '0;
`ifdef OPERM_KP_GEN_XOR_EN
      r_shift <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_cfg_fire) begin
        r_mode  <= mode_t'(cfg_mode);
        r_rot   <= cfg_shift;
        r_step  <= cfg_step;
        r_count <= cfg_count;
        r_sel   <= cfg_sel;
        r_k     <= '0;
`ifdef OPERM_KP_GEN_XOR_EN
        r_shift <= cfg_shift;
`endif
        if (w_load) begin
          r_valid <= 1'b1;
          r_dat   <= w_dat;
        end
      end else if (r_state == RUN) begin
        if (abort) begin
          r_valid <= 1'b0;
        end else if (w_beat_fire) begin
          if (w_last) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_k     <= r_k + 16'd1;
            r_rot   <= w_lane_rot;
            r_dat   <= w_dat;
          end
        end
      end
    end
  end

  assign cfg_ready  = w_cfg_ready;
  assign i_kp_dat   = r_dat;
  assign i_kp_valid = r_valid;
  assign done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_operm_kp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operm_kp_gen
//  Desc     : Self-checking bench for operm_kp_gen (SLICES=8). Expected key
//             words come from a direct per-beat model (k*step) pushed into a
//             scoreboard queue and popped on each accepted beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_operm_kp_gen;

  localparam int SL = 8;
  localparam int LG = 3;
  localparam int SE = 4;
  localparam int DW = SE + SL * LG;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [1:0]    cfg_mode;
  logic [LG-1:0] cfg_shift;
  logic [LG-1:0] cfg_step;
  logic [15:0]   cfg_count;
  logic [SE-1:0] cfg_sel;
  logic          abort;
  logic [DW-1:0] i_kp_dat;
  logic          i_kp_valid;
  logic          i_kp_ready;
  logic          done;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb[$];

  typedef struct {
    logic [1:0]  mode;
    logic [2:0]  shift;
    logic [2:0]  step;
    logic [15:0] count;
    logic [3:0]  sel;
    logic [2:0]  e0;
    logic [2:0]  e5;
    logic [2:0]  e7;
  } vec_t;

  vec_t vecs[6];

  operm_kp_gen #(.SLICES(SL), .LOG2SLICES(LG), .SELIN(SE)) dut (
    .clk        (clk),
    .reset      (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_mode   (cfg_mode),
    .cfg_shift  (cfg_shift),
    .cfg_step   (cfg_step),
    .cfg_count  (cfg_count),
    .cfg_sel    (cfg_sel),
    .abort      (abort),
    .i_kp_dat   (i_kp_dat),
    .i_kp_valid (i_kp_valid),
    .i_kp_ready (i_kp_ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] m, input logic [2:0] sh,
                                          input logic [2:0] st, input int k, input logic [3:0] sl);
    logic [DW-1:0] w;
    int v;
    w = '0;
    w[DW-1 -: SE] = sl;
    for (int i = 0; i < SL; i++) begin
      v = i;
      if (m == 2'd0) v = (i + int'(sh) + k * int'(st)) % SL;
      else if (m == 2'd1) v = ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
`ifdef OPERM_KP_GEN_XOR_EN
      else if (m == 2'd2) v = i ^ int'(sh);
`endif
      w[LG*i +: LG] = v[LG-1:0];
    end
    return w;
  endfunction

  // rdy_mode 0: ready always high; 1: ready pattern 1,0,0 repeating
  task automatic run_prog(input logic [1:0] m, input logic [2:0] sh, input logic [2:0] st,
                          input logic [15:0] cnt, input logic [3:0] sl, input int rdy_mode,
                          input int abort_at, input bit chk_first,
                          input logic [2:0] e0, input logic [2:0] e5, input logic [2:0] e7);
    int acc;
    int cyc;
    logic rdy;
    logic prev_hold;
    logic [DW-1:0] prev_dat;
    logic [DW-1:0] got;
    i_kp_ready = 1'b0;
    cfg_mode   = m;
    cfg_shift  = sh;
    cfg_step   = st;
    cfg_count  = cnt;
    cfg_sel    = sl;
    cfg_valid  = 1'b1;
    chk("cfg_ready_idle", {63'd0, cfg_ready}, 64'd1);
    for (int k = 0; k < int'(cnt); k++) sb.push_back(model(m, sh, st, k, sl));
    tick();
    cfg_valid = 1'b0;
    if (cnt == 16'd0) begin
      for (int c = 0; c < 3; c++) begin
        chk("cnt0_valid", {63'd0, i_kp_valid}, 64'd0);
        chk("cnt0_done", {63'd0, done}, 64'd0);
        chk("cnt0_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        tick();
      end
      return;
    end
    chk("latency1_valid", {63'd0, i_kp_valid}, 64'd1);
    acc = 0;
    cyc = 0;
    prev_hold = 1'b0;
    prev_dat = '0;
    while (acc < int'(cnt) && cyc < 500) begin
      rdy = (rdy_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      i_kp_ready = rdy;
      if (abort_at >= 0 && acc == abort_at && i_kp_valid) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_valid", {63'd0, i_kp_valid}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_cfg_ready", {63'd0, cfg_ready}, 64'd1);
        tick();
        chk("abort_done_late", {63'd0, done}, 64'd0);
        sb.delete();
        i_kp_ready = 1'b0;
        return;
      end
      chk("run_valid", {63'd0, i_kp_valid}, 64'd1);
      chk("run_cfg_ready", {63'd0, cfg_ready}, 64'd0);
      chk("run_done", {63'd0, done}, 64'd0);
      if (prev_hold) chk("stall_hold", {{(64-DW){1'b0}}, i_kp_dat}, {{(64-DW){1'b0}}, prev_dat});
      if (i_kp_valid && rdy) begin
        got = i_kp_dat;
        if (sb.size() == 0) begin
          chk("sb_underflow", 64'd1, 64'd0);
        end else begin
          chk("beat", {{(64-DW){1'b0}}, got}, {{(64-DW){1'b0}}, sb.pop_front()});
        end
        if (chk_first && acc == 0) begin
          chk("slice0", {61'd0, got[2:0]}, {61'd0, e0});
          chk("slice5", {61'd0, got[17:15]}, {61'd0, e5});
          chk("slice7", {61'd0, got[23:21]}, {61'd0, e7});
        end
        acc++;
      end
      prev_hold = i_kp_valid && !rdy;
      prev_dat  = i_kp_dat;
      tick();
      cyc++;
    end
    if (acc < int'(cnt)) chk("beat_timeout", 64'd1, 64'd0);
    chk("done_pulse", {63'd0, done}, 64'd1);
    chk("end_valid", {63'd0, i_kp_valid}, 64'd0);
    chk("end_cfg_ready", {63'd0, cfg_ready}, 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    i_kp_ready = 1'b0;
    tick();
    chk("done_one_cycle", {63'd0, done}, 64'd0);
  endtask

  initial begin
    //         mode  sh    st    count  sel   e0    e5    e7
    vecs[0] = '{2'd0, 3'd1, 3'd2, 16'd3,  4'h5, 3'd1, 3'd6, 3'd0};
    vecs[1] = '{2'd1, 3'd0, 3'd0, 16'd1,  4'hA, 3'd0, 3'd5, 3'd7};
`ifdef OPERM_KP_GEN_XOR_EN
    vecs[2] = '{2'd2, 3'd3, 3'd0, 16'd2,  4'h3, 3'd3, 3'd6, 3'd4};
`else
    vecs[2] = '{2'd2, 3'd3, 3'd0, 16'd2,  4'h3, 3'd0, 3'd5, 3'd7};
`endif
    vecs[3] = '{2'd3, 3'd5, 3'd3, 16'd2,  4'h6, 3'd0, 3'd5, 3'd7};
    vecs[4] = '{2'd0, 3'd7, 3'd7, 16'd10, 4'hF, 3'd7, 3'd4, 3'd6};
    vecs[5] = '{2'd0, 3'd0, 3'd1, 16'd9,  4'h1, 3'd0, 3'd5, 3'd7};

    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_mode   = '0;
    cfg_shift  = '0;
    cfg_step   = '0;
    cfg_count  = '0;
    cfg_sel    = '0;
    abort      = 1'b0;
    i_kp_ready = 1'b0;
    #12;
    chk("rst_valid", {63'd0, i_kp_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dat", {{(64-DW){1'b0}}, i_kp_dat}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_cfg_ready", {63'd0, cfg_ready}, 64'd1);

    // Table-driven programs, ready held high
    for (int v = 0; v < 6; v++) begin
      run_prog(vecs[v].mode, vecs[v].shift, vecs[v].step, vecs[v].count, vecs[v].sel,
               0, -1, 1'b1, vecs[v].e0, vecs[v].e5, vecs[v].e7);
    end

    // Explicit bit-reverse word: addresses 0,4,2,6,1,5,3,7 under sel=A
    cfg_mode = 2'd1; cfg_shift = 3'd0; cfg_step = 3'd0; cfg_count = 16'd1; cfg_sel = 4'hA;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk("bitrev_valid", {63'd0, i_kp_valid}, 64'd1);
    chk("bitrev_word", {{(64-DW){1'b0}}, i_kp_dat},
        {36'd0, 4'hA, 3'd7, 3'd3, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4, 3'd0});
    i_kp_ready = 1'b1;
    tick();
    i_kp_ready = 1'b0;
    chk("bitrev_done", {63'd0, done}, 64'd1);
    tick();

    // Ready toggling 1,0,0: beats held through stalls
    run_prog(2'd0, 3'd2, 3'd3, 16'd4, 4'h7, 1, -1, 1'b0, 3'd0, 3'd0, 3'd0);

    // Abort while beat 2 of 5 is presented
    run_prog(2'd0, 3'd0, 3'd1, 16'd5, 4'h2, 0, 2, 1'b0, 3'd0, 3'd0, 3'd0);

    // Abort with a simultaneous cfg handshake: program is ignored
    cfg_mode = 2'd0; cfg_count = 16'd2; cfg_valid = 1'b1; abort = 1'b1;
    tick();
    cfg_valid = 1'b0; abort = 1'b0;
    chk("abort_cfg_ignored_valid", {63'd0, i_kp_valid}, 64'd0);
    chk("abort_cfg_ignored_ready", {63'd0, cfg_ready}, 64'd1);

    // Count of zero: no beats, no done
    run_prog(2'd0, 3'd1, 3'd1, 16'd0, 4'h4, 0, -1, 1'b0, 3'd0, 3'd0, 3'd0);

    // Asynchronous reset in the middle of a program
    cfg_mode = 2'd0; cfg_shift = 3'd3; cfg_step = 3'd1; cfg_count = 16'd6; cfg_sel = 4'h9;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    i_kp_ready = 1'b1;
    tick();
    tick();
    chk("mid_run_valid", {63'd0, i_kp_valid}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {63'd0, i_kp_valid}, 64'd0);
    chk("async_rst_dat", {{(64-DW){1'b0}}, i_kp_dat}, 64'd0);
    chk("async_rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_idle_valid", {63'd0, i_kp_valid}, 64'd0);
      chk("post_rst_idle_done", {63'd0, done}, 64'd0);
      chk("post_rst_idle_ready", {63'd0, cfg_ready}, 64'd1);
    end
    i_kp_ready = 1'b0;

    // Generator still usable after the reset
    run_prog(2'd0, 3'd1, 3'd2, 16'd3, 4'h5, 0, -1, 1'b1, 3'd1, 3'd6, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
